// File: rtl/imem_loader.sv
// imem_loader
// Turns a length-prefixed byte stream from the boot receiver into little-endian
// 32-bit word writes on the instruction RAM write port. Words are placed at
// consecutive word-aligned byte addresses from BASE_ADDR. The fetch side can then
// read back the same image it was streamed.
module imem_loader #(
    parameter int V         = 32,
    parameter int RAM_SIZE  = 512,
    parameter int BASE_ADDR = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic         rx_ready,
    output logic         imem_we,
    output logic [V-1:0] imem_addr,
    output logic [V-1:0] imem_wdata,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [15:0]  words_loaded
);

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_e;

    localparam logic [15:0]  RamSizeW  = 16'(RAM_SIZE);
    localparam logic [V-1:0] BaseAddrW = V'(BASE_ADDR);

    state_e       state_q, state_d;
    logic [15:0]  count_q, count_d;
    logic [15:0]  idx_q, idx_d;
    logic [1:0]   lane_q, lane_d;
    logic [23:0]  word_q, word_d;
    logic [V-1:0] addr_q, addr_d;
    logic [V-1:0] wdata_q, wdata_d;
    logic [15:0]  words_q, words_d;
    logic [15:0]  nextCount;

    // Next-state, datapath updates and Moore outputs. Everything defaults to hold/inactive first.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        idx_d     = idx_q;
        lane_d    = lane_q;
        word_d    = word_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        words_d   = words_q;
        nextCount = {rx_data, count_q[7:0]};
        rx_ready  = 1'b0;
        imem_we   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;

        case (state_q)
            IDLE, DONE, ERR: begin
                done  = (state_q == DONE);
                error = (state_q == ERR);
                if (start) begin
                    state_d = LEN0;
                    count_d = 16'd0;
                    idx_d   = 16'd0;
                    lane_d  = 2'd0;
                    words_d = 16'd0;
                end
            end
            LEN0: begin
                busy     = 1'b1;
                rx_ready = 1'b1;
                if (rx_valid) begin
                    count_d = {count_q[15:8], rx_data};
                    state_d = LEN1;
                end
            end
            LEN1: begin
                busy     = 1'b1;
                rx_ready = 1'b1;
                if (rx_valid) begin
                    count_d = nextCount;
                    lane_d  = 2'd0;
                    if (nextCount == 16'd0) begin
                        state_d = DONE;
                    end else if (nextCount > RamSizeW) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                busy     = 1'b1;
                rx_ready = 1'b1;
                if (rx_valid) begin
                    lane_d = lane_q + 2'd1;
                    case (lane_q)
                        2'd0: word_d[7:0]   = rx_data;
                        2'd1: word_d[15:8]  = rx_data;
                        2'd2: word_d[23:16] = rx_data;
                        default: begin
                            addr_d  = BaseAddrW + V'({idx_q, 2'b00});
                            wdata_d = V'({rx_data, word_q});
                            state_d = WRITE;
                        end
                    endcase
                end
            end
            WRITE: begin
                busy    = 1'b1;
                imem_we = 1'b1;
                idx_d   = idx_q + 16'd1;
                words_d = words_q + 16'd1;
                if ((idx_q + 16'd1) == count_q) begin
                    state_d = DONE;
                end else begin
                    state_d = DATA;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; an asynchronous reset aborts any load in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            idx_q   <= '0;
            lane_q  <= '0;
            word_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            lane_q  <= lane_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            words_q <= words_d;
        end
    end

    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign words_loaded = words_q;

endmodule
